// File: rtl/pb_debounce_bank.sv
// Bank of active-low push-button conditioners: synchroniser, stability debounce, and press/release/long-press pulses.
// Define PB_LONG_PRESS_EN to build the hold counter, the DOWN_LONG state and long_pulse; otherwise long_pulse is 0.
module pb_debounce_bank #(
  parameter int NUM_PB      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] pressed,
  output logic [NUM_PB-1:0] press_pulse,
  output logic [NUM_PB-1:0] release_pulse,
  output logic [NUM_PB-1:0] long_pulse
);

  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

`ifdef PB_LONG_PRESS_EN
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  typedef enum logic [1:0] {UP, DOWN, DOWN_LONG} ch_state_t;
`else
  typedef enum logic [0:0] {UP, DOWN} ch_state_t;
`endif

  for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   stab;
    logic                   stab_nxt;
    logic [DW-1:0]          dcnt;
    logic [DW-1:0]          dcnt_nxt;
    logic                   fall;
    logic                   rise;
    ch_state_t              state;
    logic                   pressed_r;
    logic                   press_r;
    logic                   release_r;
    logic                   long_r;

    // Presetting to 1 makes reset look like a released button, so no spurious press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '1;
      else        sync <= {sync[SYNC_STAGES-2:0], pb[i]};
    end
    assign s = sync[SYNC_STAGES-1];

    always_comb begin
      stab_nxt = stab;
      dcnt_nxt = dcnt;
      if (s == stab) begin
        dcnt_nxt = '0;
      end else if (dcnt == DW'(DB_CYCLES - 1)) begin
        stab_nxt = s;
        dcnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab <= 1'b1;
        dcnt <= '0;
      end else begin
        stab <= stab_nxt;
        dcnt <= dcnt_nxt;
      end
    end

    // Edges are taken from the next stable value so pulses coincide with the accepting edge.
    assign fall = stab & ~stab_nxt;
    assign rise = ~stab & stab_nxt;

`ifdef PB_LONG_PRESS_EN
    logic [HW-1:0] hcnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= UP;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
`ifdef PB_LONG_PRESS_EN
        hcnt      <= '0;
`endif
      end else begin
        pressed_r <= ~stab_nxt;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        case (state)
          UP: begin
            if (fall) begin
              state   <= DOWN;
              press_r <= 1'b1;
`ifdef PB_LONG_PRESS_EN
              hcnt    <= '0;
`endif
            end
          end
          DOWN: begin
            // Release takes priority over a long press landing on the same edge.
            if (rise) begin
              state     <= UP;
              release_r <= 1'b1;
`ifdef PB_LONG_PRESS_EN
            end else if (hcnt == HW'(LONG_CYCLES - 1)) begin
              state  <= DOWN_LONG;
              long_r <= 1'b1;
            end else begin
              hcnt <= hcnt + 1'b1;
`endif
            end
          end
`ifdef PB_LONG_PRESS_EN
          DOWN_LONG: begin
            if (rise) begin
              state     <= UP;
              release_r <= 1'b1;
            end
          end
`endif
          default: state <= UP;
        endcase
      end
    end

    assign pressed[i]       = pressed_r;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign long_pulse[i]    = long_r;
  end

endmodule

// File: tb/tb_pb_debounce_bank.sv
// Scoreboard bench for pb_debounce_bank: directed button patterns push expected pulse events; a monitor pops and compares.
module tb_pb_debounce_bank;
  localparam int NPB = 4;
  localparam int SS  = 2;
  localparam int DB  = 16;
  localparam int LC  = 50;
  localparam int LAT = SS + DB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NPB-1:0] pb = '1;
  logic [NPB-1:0] pressed;
  logic [NPB-1:0] press_pulse;
  logic [NPB-1:0] release_pulse;
  logic [NPB-1:0] long_pulse;

  pb_debounce_bank #(
    .NUM_PB(NPB), .SYNC_STAGES(SS), .DB_CYCLES(DB), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb(pb), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  // entry = {cycle[31:0], press[3:0], release[3:0], long[3:0]}
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    logic [31:0] at32;
    at32 = at;
    exp_q.push_back({at32, p, r, l});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: every non-zero pulse vector must match the head of the queue, at the expected cycle
  always @(negedge clk) begin
    if (rst_n && (|press_pulse || |release_pulse || |long_pulse)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {20'd0, press_pulse, release_pulse, long_pulse}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e[43:12]);
        check("pulse_vec", {20'd0, press_pulse, release_pulse, long_pulse}, {20'd0, mon_e[11:0]});
      end
    end
  end

  // driver
  initial begin
    int n;
    pb = '1;
    rst_n = 1'b0;
    idle(3);
    check("reset_out", {16'd0, pressed, press_pulse, release_pulse, long_pulse}, 32'd0);
    rst_n = 1'b1;
    idle(40);
    check("idle_pressed", {28'd0, pressed}, 32'd0);

    // ch0 basic press / release with latency boundary
    pb[0] = 1'b0;
    expect_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    idle(LAT - 1);
    check("pressed_early", {28'd0, pressed}, 32'd0);
    idle(1);
    check("pressed_on_time", {28'd0, pressed}, 32'h1);
    idle(20);
    pb[0] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    idle(40);
    check("released_ch0", {28'd0, pressed}, 32'd0);

    // glitch one cycle too short for the debounce window: rejected
    pb[2] = 1'b0;
    idle(DB - 1);
    pb[2] = 1'b1;
    idle(40);
    check("short_glitch", {28'd0, pressed}, 32'd0);

    // exactly DB cycles low: accepted, then released DB cycles later
    pb[2] = 1'b0;
    expect_ev(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
    idle(DB);
    pb[2] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    idle(40);

    // ch1 bounce: 5 low / 3 high for 200 cycles
    for (int k = 0; k < 25; k++) begin
      pb[1] = 1'b0;
      idle(5);
      pb[1] = 1'b1;
      idle(3);
    end
    check("bounce_pressed", {28'd0, pressed}, 32'd0);
    idle(40);

    // ch2 long hold 200 cycles
    pb[2] = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 4'b0100, 4'b0000, 4'b0000);
`ifdef PB_LONG_PRESS_EN
    expect_ev(n + LAT + LC, 4'b0000, 4'b0000, 4'b0100);
`endif
    idle(200);
    check("long_held", {28'd0, pressed}, 32'h4);
    pb[2] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    idle(40);

    // ch2 held 30 cycles: no long pulse
    pb[2] = 1'b0;
    expect_ev(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
    idle(30);
    pb[2] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    idle(40);

    // release lands on the same edge as the terminal hold count: release wins
    pb[2] = 1'b0;
    expect_ev(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
    idle(LC);
    pb[2] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    idle(40);

    // one cycle longer: long pulse then release
    pb[2] = 1'b0;
    n = cyc;
    expect_ev(n + LAT, 4'b0100, 4'b0000, 4'b0000);
`ifdef PB_LONG_PRESS_EN
    expect_ev(n + LAT + LC, 4'b0000, 4'b0000, 4'b0100);
`endif
    idle(LC + 1);
    pb[2] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    idle(40);

    // ch0 and ch3 together
    pb = 4'b0110;
    expect_ev(cyc + LAT, 4'b1001, 4'b0000, 4'b0000);
    idle(30);
    check("dual_pressed", {28'd0, pressed}, 32'h9);
    pb = 4'b1111;
    expect_ev(cyc + LAT, 4'b0000, 4'b1001, 4'b0000);
    idle(40);

    // reset while ch0 is held
    pb[0] = 1'b0;
    expect_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    idle(30);
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", {16'd0, pressed, press_pulse, release_pulse, long_pulse}, 32'd0);
    idle(3);
    check("mid_reset_hold", {16'd0, pressed, press_pulse, release_pulse, long_pulse}, 32'd0);
    rst_n = 1'b1;
    expect_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    idle(LAT - 1);
    check("post_reset_early", {28'd0, pressed}, 32'd0);
    idle(1);
    check("post_reset_pressed", {28'd0, pressed}, 32'h1);
    idle(20);
    pb[0] = 1'b1;
    expect_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    idle(40);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
